// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: routes load/store requests to the external RAM bus
// or the memory-mapped UART, stalls the pipeline during RAM waits and bounds each wait.
module mem_access_ctrl #(
  parameter int unsigned ACK_TIMEOUT    = 15,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_op,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_data,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        ram_req,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic        ram_ack,
  input  logic        uart_rx_ready,
  input  logic        uart_tx_ready,
  input  logic [15:0] uart_rdata,
  output logic        uart_rd,
  output logic        uart_wr,
  output logic [15:0] uart_wdata
);

  localparam logic [1:0] OP_READ      = 2'b01;
  localparam logic [1:0] OP_WRITE     = 2'b10;
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state_p1, state_nxt;
  logic [15:0] mem_data_p1;
  logic [7:0]  cnt_p1;
  logic        ram_req_p1, ram_we_p1, bus_err_p1;
  logic [15:0] ram_addr_p1, ram_wdata_p1;

  logic is_rd, is_wr, is_stat, is_data, is_ram, timeout;

  assign is_rd   = (mem_op == OP_READ);
  assign is_wr   = (mem_op == OP_WRITE);
  assign is_stat = (mem_addr == UART_STAT_ADDR);
  assign is_data = (mem_addr == UART_DATA_ADDR);
  assign is_ram  = (is_rd || is_wr) && !is_stat && !is_data;
  // Ack on the same edge as the last allowed wait cycle takes precedence.
  assign timeout = (state_p1 == BUS) && !ram_ack && (cnt_p1 == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_p1 <= IDLE;
    else      state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      IDLE:    if (is_ram) state_nxt = BUS;
      BUS:     if (ram_ack || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // IDLE -> BUS: latch request; BUS: hold until ack or timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_data_p1  <= '0;
      cnt_p1       <= '0;
      ram_req_p1   <= 1'b0;
      ram_we_p1    <= 1'b0;
      ram_addr_p1  <= '0;
      ram_wdata_p1 <= '0;
      bus_err_p1   <= 1'b0;
    end else begin
      bus_err_p1 <= timeout;
      case (state_p1)
        IDLE: begin
          if (is_ram) begin
            ram_req_p1   <= 1'b1;
            ram_we_p1    <= is_wr;
            ram_addr_p1  <= mem_addr;
            ram_wdata_p1 <= mem_wdata;
            cnt_p1       <= '0;
          end
        end
        BUS: begin
          if (ram_ack) begin
            ram_req_p1 <= 1'b0;
            ram_we_p1  <= 1'b0;
            if (!ram_we_p1) mem_data_p1 <= ram_rdata;
          end else if (timeout) begin
            ram_req_p1 <= 1'b0;
            ram_we_p1  <= 1'b0;
            if (!ram_we_p1) mem_data_p1 <= '0;
          end else begin
            cnt_p1 <= cnt_p1 + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // UART accesses complete combinationally in IDLE; nothing is driven while in reset.
  always_comb begin
    mem_data  = mem_data_p1;
    mem_stall = 1'b0;
    uart_rd   = 1'b0;
    uart_wr   = 1'b0;
    if (rst) begin
      case (state_p1)
        IDLE: begin
          if (is_stat && is_rd) mem_data = {14'b0, uart_rx_ready, uart_tx_ready};
          if (is_data && is_rd) begin
            mem_data = uart_rdata;
            uart_rd  = uart_rx_ready;
          end
          if (is_data && is_wr) begin
            uart_wr   = uart_tx_ready;
            mem_stall = !uart_tx_ready;
          end
          if (is_ram) mem_stall = 1'b1;
        end
        BUS:     mem_stall = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus_err    = bus_err_p1;
  assign ram_req    = ram_req_p1;
  assign ram_we     = ram_we_p1;
  assign ram_addr   = ram_addr_p1;
  assign ram_wdata  = ram_wdata_p1;
  assign uart_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: scripted RAM ack timing, UART accesses,
// asynchronous reset mid-access; RAM results go through an expected-value queue.
module tb_mem_access_ctrl;

  localparam int T = 15;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_op;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_data;
  logic        mem_stall, bus_err;
  logic        ram_req, ram_we;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ack;
  logic        uart_rx_ready, uart_tx_ready;
  logic [15:0] uart_rdata;
  logic        uart_rd, uart_wr;
  logic [15:0] uart_wdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ACK_TIMEOUT(T),
    .UART_DATA_ADDR(16'hBF00),
    .UART_STAT_ADDR(16'hBF01)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data(mem_data), .mem_stall(mem_stall), .bus_err(bus_err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .uart_rx_ready(uart_rx_ready), .uart_tx_ready(uart_tx_ready),
    .uart_rdata(uart_rdata), .uart_rd(uart_rd), .uart_wr(uart_wr),
    .uart_wdata(uart_wdata)
  );

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          bus_cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] model_mem = '0;
  int          stalls, wr_pulses;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One RAM access; waits = no-ack BUS cycles before ack, waits >= T means never ack.
  task automatic ram_txn(input string tag, input logic [1:0] op, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rdata, input int waits);
    exp_t e;
    int   k = 0;
    int   nst = 1;
    int   unstable = 0;
    bit   done = 0;
    mem_op = op; mem_addr = addr; mem_wdata = wdata; ram_ack = 1'b0;
    #1;
    check_eq({tag, ".idle_stall"}, mem_stall, 1);
    check_eq({tag, ".req_late"}, ram_req, 0);
    e.bus_cycles = (waits < T) ? waits + 1 : T;
    e.err        = (waits >= T);
    if (op == OP_RD) model_mem = (waits < T) ? rdata : 16'h0000;
    e.data = model_mem;
    sb.push_back(e);
    for (int s = 0; s < 300 && !done; s++) begin
      @(posedge clk); #2;
      if (mem_stall) begin
        nst++;
        if (ram_req !== 1'b1 || ram_addr !== addr || ram_wdata !== wdata ||
            ram_we !== (op == OP_WR)) unstable++;
        ram_ack   = (k == waits);
        ram_rdata = (k == waits) ? rdata : 16'hDEAD;
        k++;
      end else begin
        ram_ack = 1'b0;
        done    = 1;
        #1;
        if (sb.size() == 0) check_eq({tag, ".sb_empty"}, 1, 0);
        else begin
          e = sb.pop_front();
          check_eq({tag, ".mem_data"}, mem_data, e.data);
          check_eq({tag, ".bus_err"}, bus_err, e.err);
          check_eq({tag, ".bus_cycles"}, k, e.bus_cycles);
          check_eq({tag, ".stalls"}, nst, e.bus_cycles + 1);
        end
        check_eq({tag, ".req_done"}, ram_req, 0);
      end
    end
    if (!done) check_eq({tag, ".no_done"}, 0, 1);
    check_eq({tag, ".bus_stable"}, unstable, 0);
    mem_op = OP_NOP;
    @(posedge clk); #2; #1;
    check_eq({tag, ".err_pulse"}, bus_err, 0);
    check_eq({tag, ".idle_free"}, mem_stall, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_op = OP_NOP; mem_addr = '0; mem_wdata = '0;
    ram_rdata = '0; ram_ack = 1'b0;
    uart_rx_ready = 1'b0; uart_tx_ready = 1'b0; uart_rdata = '0;
    #1;
    check_eq("rst.mem_data", mem_data, 0);
    check_eq("rst.ram_req", ram_req, 0);
    check_eq("rst.bus_err", bus_err, 0);
    check_eq("rst.stall", mem_stall, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;

    ram_txn("rd_fast", OP_RD, 16'h4000, 16'h0000, 16'h1234, 0);
    ram_txn("wr_wait3", OP_WR, 16'h8001, 16'hBEEF, 16'h0000, 3);
    check_eq("wr.mem_hold", mem_data, model_mem);

    // Reset in the middle of a write: everything clears without a clock edge.
    mem_op = OP_WR; mem_addr = 16'h8001; mem_wdata = 16'hBEEF; ram_ack = 1'b0;
    @(posedge clk); #2; #1;
    check_eq("mid.req_pre", ram_req, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid.ram_req", ram_req, 0);
    check_eq("mid.ram_we", ram_we, 0);
    check_eq("mid.ram_addr", ram_addr, 0);
    check_eq("mid.ram_wdata", ram_wdata, 0);
    check_eq("mid.mem_data", mem_data, 0);
    check_eq("mid.stall", mem_stall, 0);
    check_eq("mid.bus_err", bus_err, 0);
    model_mem = '0;
    mem_op = OP_NOP;
    #1 rst = 1'b1;
    @(posedge clk); #2; #1;
    check_eq("post.stall", mem_stall, 0);
    check_eq("post.req", ram_req, 0);
    @(posedge clk); #2;

    ram_txn("rd_wait2", OP_RD, 16'h0123, 16'h0000, 16'hCAFE, 2);
    ram_txn("rd_tmo", OP_RD, 16'h2000, 16'h0000, 16'h5555, T);
    ram_txn("rd_ack15", OP_RD, 16'h2002, 16'h0000, 16'h7777, T - 1);
    ram_txn("wr_tmo", OP_WR, 16'hFFFF, 16'h1111, 16'h0000, T);

    // UART status and data reads
    uart_rx_ready = 1'b1; uart_tx_ready = 1'b0; mem_op = OP_RD; mem_addr = 16'hBF01; #1;
    check_eq("stat.rx", mem_data, 16'h0002);
    check_eq("stat.stall", mem_stall, 0);
    check_eq("stat.rd", uart_rd, 0);
    uart_rx_ready = 1'b0; uart_tx_ready = 1'b1; #1;
    check_eq("stat.tx", mem_data, 16'h0001);
    uart_rdata = 16'hA5A5; uart_rx_ready = 1'b0; mem_addr = 16'hBF00; #1;
    check_eq("drd.data", mem_data, 16'hA5A5);
    check_eq("drd.no_rd", uart_rd, 0);
    check_eq("drd.stall", mem_stall, 0);
    uart_rx_ready = 1'b1; #1;
    check_eq("drd.rd", uart_rd, 1);

    // UART data write while the transmitter is busy for 4 cycles
    @(posedge clk); #2;
    uart_rx_ready = 1'b0; uart_tx_ready = 1'b0; mem_op = OP_WR; mem_wdata = 16'h55AA;
    stalls = 0; wr_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      stalls += int'(mem_stall);
      wr_pulses += int'(uart_wr);
      @(posedge clk); #2;
    end
    uart_tx_ready = 1'b1; #1;
    stalls += int'(mem_stall);
    wr_pulses += int'(uart_wr);
    check_eq("dwr.wdata", uart_wdata, 16'h55AA);
    @(posedge clk); #2;
    mem_op = OP_NOP; #1;
    wr_pulses += int'(uart_wr);
    check_eq("dwr.stalls", stalls, 4);
    check_eq("dwr.pulses", wr_pulses, 1);

    mem_op = OP_WR; mem_addr = 16'hBF01; #1;
    check_eq("swr.stall", mem_stall, 0);
    check_eq("swr.wr", uart_wr, 0);
    mem_op = OP_NOP; #1;
    check_eq("uart.no_reg", mem_data, model_mem);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage access controller for the 16-bit pipeline: it turns the MEM-stage load/store request into transactions on the external RAM bus or the memory-mapped UART and returns load data on `mem_data`, the memory operand consumed by the write-back data mux. It holds the pipeline with `mem_stall` while a RAM access waits for acknowledge, and bounds every bus wait with a timeout.

## Interface
- `ACK_TIMEOUT`, 15: maximum BUS-state cycles to wait for `ram_ack`, range 1–255.
- `UART_DATA_ADDR`, 16'hBF00: UART data register address.
- `UART_STAT_ADDR`, 16'hBF01: UART status register address.

- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_op`  in  2  00 NOP, 01 READ, 10 WRITE, 11 treated as NOP.
- `mem_addr`  in  16  access address.
- `mem_wdata`  in  16  store data.
- `mem_data`  out  16  load result to the write-back mux.
- `mem_stall`  out  1  freezes IF/ID/EX/MEM when high.
- `bus_err`  out  1  one-cycle pulse on RAM timeout.
- `ram_req`  out  1  RAM request.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  16  RAM address.
- `ram_wdata`  out  16  RAM write data.
- `ram_rdata`  in  16  RAM read data, valid when `ram_ack`=1.
- `ram_ack`  in  1  RAM acknowledge.
- `uart_rx_ready`  in  1  receive byte available.
- `uart_tx_ready`  in  1  transmitter can accept a byte.
- `uart_rdata`  in  16  received data.
- `uart_rd`  out  1  one-cycle read-strobe pulse.
- `uart_wr`  out  1  one-cycle write-strobe pulse.
- `uart_wdata`  out  16  equals `mem_wdata`.

## Operation
- FSM states: IDLE, BUS, DONE. Reset state is IDLE.
- Reset values: `mem_data`=0, `ram_req`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `bus_err`=0, timeout counter=0.
- IDLE, NOP: `mem_stall`=0, no strobes.
- IDLE, access to `UART_STAT_ADDR`:
  - READ: `mem_data` = {14'b0, `uart_rx_ready`, `uart_tx_ready`}, combinational, no stall.
  - WRITE: ignored, no stall.
- IDLE, access to `UART_DATA_ADDR`:
  - READ: `mem_data` = `uart_rdata`, combinational, no stall. `uart_rd`=1 only if `uart_rx_ready`=1.
  - WRITE with `uart_tx_ready`=1: `uart_wr`=1, no stall.
  - WRITE with `uart_tx_ready`=0: `mem_stall`=1, FSM stays in IDLE until `uart_tx_ready`=1.
- IDLE, any other address (RAM):
  - `mem_stall`=1 combinationally.
  - Next edge: latch `ram_addr`, `ram_we` (1 for WRITE), `ram_wdata`; set `ram_req`=1; clear counter; go to BUS.
- BUS: `mem_stall`=1. `ram_req`, `ram_we`, `ram_addr`, `ram_wdata` are held stable.
  - Edge with `ram_ack`=1: drop `ram_req` and `ram_we`. For READ, register `ram_rdata` into `mem_data`. Go to DONE.
  - Edge with no ack: counter += 1.
  - Edge where the counter reaches `ACK_TIMEOUT` with no ack: drop `ram_req`; set `mem_data`=0 for READ; pulse `bus_err` for one cycle; go to DONE.
  - `ram_ack` on the same edge as the timeout: ack wins, no `bus_err`.
- DONE: `mem_stall`=0 and `mem_data` holds the registered value, so the pipeline advances on this edge. Unconditionally return to IDLE.
- Outside the cases above, `mem_data` holds its last registered value. Combinational UART values are never registered.
- Reset asserted mid-access: outputs go to reset values immediately, without waiting for a clock edge, and any in-flight RAM request is abandoned.

## Timing
- UART and status accesses: zero added latency, single cycle.
- RAM access acknowledged in the first BUS cycle: IDLE → BUS → DONE = 3 cycles, of which 2 are stalled.
- Each extra wait cycle adds 1 stall cycle.
- Worst case: `ACK_TIMEOUT`+2 cycles.
- `ram_req` rises 1 cycle after the request appears in IDLE.
- `bus_err` is high exactly during the DONE cycle that follows a timeout.
- The same instruction is never issued to RAM twice: DONE always exits to IDLE with `mem_stall`=0.

## Test plan
- Reset with `rst`=0 mid-BUS, `ram_req`=1: all outputs drop to 0 without a clock edge; after release, FSM is in IDLE with `mem_stall`=0.
- RAM READ at 0x4000, `ram_ack` on the first BUS cycle with `ram_rdata`=0x1234: `mem_stall` high for 2 cycles; `mem_data`=0x1234 in DONE.
- RAM WRITE at 0x8001 of 0xBEEF, ack after 3 wait cycles: `ram_addr`/`ram_wdata`/`ram_we` stable for 4 BUS cycles; `mem_stall` high for 5 cycles.
- No ack with `ACK_TIMEOUT`=15: `bus_err` pulses once; `mem_data`=0; `ram_req` low after 15 BUS cycles. Repeat with ack on the 15th edge: no `bus_err`.
- UART: status read with rx=1/tx=0 → `mem_data`=0x0002. Data write with tx_ready=0 for 4 cycles: stall for 4 cycles, then a single `uart_wr` pulse.
- UART data read with `uart_rx_ready`=0: `mem_data`=`uart_rdata`, no `uart_rd` pulse, no stall.
